alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: DATA_W, 16, ALU operand/accumulator width.
REQ-002 Parameter: OPC_W, 5, ALU opcode width.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  instruction/extension word offered.
REQ-006 Port: in_word  input  DATA_W  instruction or extension word.
REQ-007 Port: in_ready  output  1  block accepts in_word this cycle.
REQ-008 Port: alu_opcode  output  OPC_W  opcode to ALU.
REQ-009 Port: alu_operand  output  DATA_W  operand to ALU.
REQ-010 Port: alu_write / alu_writeu / alu_read  output  1 each  ALU strobes (load acc, load acc upper, read acc).
REQ-011 Port: alu_accout  input  DATA_W  ALU accumulator output.
REQ-012 Port: alu_flag  input  1  ALU flag output.
REQ-013 Port: res_valid  output  1  captured result available.
REQ-014 Port: res_data  output  DATA_W  captured accumulator value.
REQ-015 Port: res_flag  output  1  captured flag.
REQ-016 Port: res_ready  input  1  consumer takes result.

Function
REQ-017 Instruction format SHALL be: [15:14] kind (00 EXEC, 01 LOAD, 10 LOADU, 11 READ), [13:9] opcode, [8] ext, [7:0] imm8.
REQ-018 Transfer SHALL occur only when in_valid && in_ready; in_ready SHALL be high only in IDLE and WAIT_EXT.
REQ-019 FSM states SHALL be IDLE, WAIT_EXT, ISSUE, CAPTURE, HOLD.
REQ-020 IDLE: accepted word with ext=1 -> WAIT_EXT; ext=0 -> ISSUE with operand = zero-extended imm8.
REQ-021 WAIT_EXT: next accepted word SHALL be taken verbatim as operand -> ISSUE; in_valid low holds WAIT_EXT indefinitely.
REQ-022 ISSUE lasts exactly one cycle; alu_opcode/alu_operand valid throughout; exactly one strobe high: EXEC none (opcode execute), LOAD alu_write, LOADU alu_writeu, READ alu_read.
REQ-023 ISSUE -> IDLE for EXEC/LOAD/LOADU; ISSUE -> CAPTURE for READ.
REQ-024 CAPTURE SHALL register alu_accout and alu_flag into res_data/res_flag, -> HOLD with res_valid=1 next cycle.
REQ-025 HOLD: res_valid, res_data, res_flag stable until res_ready sampled high, then res_valid=0 -> IDLE same edge.
REQ-026 Latency: non-ext READ accepted at cycle N -> alu_read high N+1 -> res_valid high N+3 earliest.
REQ-027 Outside ISSUE all strobes SHALL be 0; alu_opcode SHALL be 0 for LOAD/LOADU/READ and outside ISSUE; alu_operand SHALL hold last value.
REQ-028 Strobes SHALL be registered outputs (no combinational path from in_* to alu_*).
REQ-029 No new instruction SHALL be accepted while a result is pending (back-to-back READ stalls until res_ready).

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, in_ready=0, all strobes=0, alu_opcode=0, alu_operand=0, res_valid=0, res_data=0, res_flag=0.
REQ-031 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-032 Reset during WAIT_EXT, ISSUE, CAPTURE or HOLD SHALL abort the instruction; no strobe or res_valid after release until a new instruction.

Structure
REQ-033 Shared package srp16_alu_pkg SHALL hold kind encodings, state enum, DATA_W/OPC_W defaults, field bit positions.
REQ-034 Combinational decode SHALL live in sub-module alu_issue_decode (in_word -> kind, opcode, ext, imm8 operand); FSM and registers in alu_issue_ctrl.

Verification
REQ-035 LOAD ext, words 0x4100 then 0xFFFE -> one cycle alu_write=1, alu_operand=0xFFFE, alu_opcode=0.
REQ-036 EXEC opcode 5'b00010 imm 0x05 (word 0x0405) -> one cycle alu_opcode=5'b00010, alu_operand=0x0005, no strobe; in_ready back next cycle.
REQ-037 READ (0xC000), alu_accout driven 0x1234, alu_flag=1, res_ready=0 for 5 cycles -> res_valid held, res_data=0x1234, res_flag=1, in_ready=0; res_ready=1 -> res_valid=0, IDLE.
REQ-038 LOADU ext with 2-cycle in_valid gap before 0xFF00 -> remains WAIT_EXT, then alu_writeu one cycle with 0xFF00.
REQ-039 rst_n pulsed low in WAIT_EXT and in CAPTURE -> all outputs 0 immediately; no strobe/res_valid after release; next LOAD 0x4007 issues normally.
REQ-040 Random stream with random in_valid/res_ready -> scoreboard: one strobe per instruction, order preserved, never two strobes in one cycle.

Source files
------------

// File: rtl/srp16_alu_pkg.sv
// Shared definitions for the ALU issue controller: widths, word fields, kinds, FSM states.
package srp16_alu_pkg;

    localparam int unsigned DefaultDataW = 16;
    localparam int unsigned DefaultOpcW  = 5;

    // Instruction word field positions
    localparam int unsigned KindMsb = 15;
    localparam int unsigned KindLsb = 14;
    localparam int unsigned OpcMsb  = 13;
    localparam int unsigned OpcLsb  = 9;
    localparam int unsigned ExtBit  = 8;
    localparam int unsigned ImmMsb  = 7;
    localparam int unsigned ImmLsb  = 0;

    typedef enum logic [1:0] {
        KindExec  = 2'b00,
        KindLoad  = 2'b01,
        KindLoadU = 2'b10,
        KindRead  = 2'b11
    } kind_e;

    typedef enum logic [2:0] {
        StIdle,
        StWaitExt,
        StIssue,
        StCapture,
        StHold
    } state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction input, ALU command/response and result handshake bundle.
interface alu_issue_ctrl_if
    import srp16_alu_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned OPC_W  = DefaultOpcW
);
    logic              in_valid;
    logic [DATA_W-1:0] in_word;
    logic              in_ready;
    logic [OPC_W-1:0]  alu_opcode;
    logic [DATA_W-1:0] alu_operand;
    logic              alu_write;
    logic              alu_writeu;
    logic              alu_read;
    logic [DATA_W-1:0] alu_accout;
    logic              alu_flag;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_flag;
    logic              res_ready;

    // Controller side
    modport slave (
        input  in_valid, in_word, alu_accout, alu_flag, res_ready,
        output in_ready, alu_opcode, alu_operand, alu_write, alu_writeu, alu_read,
        output res_valid, res_data, res_flag
    );

    // Environment side (instruction source, ALU, result consumer)
    modport master (
        output in_valid, in_word, alu_accout, alu_flag, res_ready,
        input  in_ready, alu_opcode, alu_operand, alu_write, alu_writeu, alu_read,
        input  res_valid, res_data, res_flag
    );
endinterface

// File: rtl/alu_issue_decode.sv
// Pure field decode of an instruction word.
module alu_issue_decode
    import srp16_alu_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned OPC_W  = DefaultOpcW
) (
    input  logic [DATA_W-1:0] word_i,
    output kind_e             kind_o,
    output logic [OPC_W-1:0]  opcode_o,
    output logic              ext_o,
    output logic [DATA_W-1:0] imm_o
);

    // Split fields; imm8 is zero-extended to operand width
    always_comb begin
        kind_o   = kind_e'(word_i[KindMsb:KindLsb]);
        opcode_o = word_i[OpcMsb:OpcLsb];
        ext_o    = word_i[ExtBit];
        imm_o    = DATA_W'(word_i[ImmMsb:ImmLsb]);
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Accepts instruction (+ optional extension) words, issues one ALU command,
// and for READ captures the accumulator into a held result.
module alu_issue_ctrl
    import srp16_alu_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned OPC_W  = DefaultOpcW
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_issue_ctrl_if.slave bus_io
);

    state_e            state_q;
    kind_e             kind_q;
    logic [OPC_W-1:0]  opc_q;
    logic              in_ready_q;
    logic [OPC_W-1:0]  alu_opcode_q;
    logic [DATA_W-1:0] alu_operand_q;
    logic              alu_write_q;
    logic              alu_writeu_q;
    logic              alu_read_q;
    logic              res_valid_q;
    logic [DATA_W-1:0] res_data_q;
    logic              res_flag_q;

    kind_e             dec_kind;
    logic [OPC_W-1:0]  dec_opc;
    logic              dec_ext;
    logic [DATA_W-1:0] dec_imm;

    kind_e             issue_kind;
    logic [OPC_W-1:0]  issue_opc;
    logic [DATA_W-1:0] issue_opd;
    logic              accept;
    logic              launch;

    alu_issue_decode #(
        .DATA_W (DATA_W),
        .OPC_W  (OPC_W)
    ) u_decode (
        .word_i   (bus_io.in_word),
        .kind_o   (dec_kind),
        .opcode_o (dec_opc),
        .ext_o    (dec_ext),
        .imm_o    (dec_imm)
    );

    // Select the command to launch: fresh decode in IDLE, saved header plus raw word in WAIT_EXT
    always_comb begin
        accept     = bus_io.in_valid && in_ready_q;
        issue_kind = dec_kind;
        issue_opc  = dec_opc;
        issue_opd  = dec_imm;
        if (state_q == StWaitExt) begin
            issue_kind = kind_q;
            issue_opc  = opc_q;
            issue_opd  = bus_io.in_word;
        end
        launch = accept && ((state_q == StWaitExt) || ((state_q == StIdle) && !dec_ext));
    end

    // FSM with all outputs registered; strobes and opcode default to 0 every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            kind_q        <= KindExec;
            opc_q         <= '0;
            in_ready_q    <= 1'b0;
            alu_opcode_q  <= '0;
            alu_operand_q <= '0;
            alu_write_q   <= 1'b0;
            alu_writeu_q  <= 1'b0;
            alu_read_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_flag_q    <= 1'b0;
        end else begin
            alu_opcode_q <= '0;
            alu_write_q  <= 1'b0;
            alu_writeu_q <= 1'b0;
            alu_read_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Also the path that raises in_ready on the first edge after reset
                    in_ready_q <= 1'b1;
                    if (accept && dec_ext) begin
                        state_q <= StWaitExt;
                        kind_q  <= dec_kind;
                        opc_q   <= dec_opc;
                    end
                end
                StWaitExt: begin
                    in_ready_q <= 1'b1;
                end
                StIssue: begin
                    if (kind_q == KindRead) begin
                        state_q    <= StCapture;
                        in_ready_q <= 1'b0;
                    end else begin
                        state_q    <= StIdle;
                        in_ready_q <= 1'b1;
                    end
                end
                StCapture: begin
                    res_data_q  <= bus_io.alu_accout;
                    res_flag_q  <= bus_io.alu_flag;
                    res_valid_q <= 1'b1;
                    state_q     <= StHold;
                end
                StHold: begin
                    if (bus_io.res_ready) begin
                        res_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    in_ready_q <= 1'b0;
                end
            endcase
            // Launch overrides the state-local assignments above
            if (launch) begin
                state_q       <= StIssue;
                in_ready_q    <= 1'b0;
                kind_q        <= issue_kind;
                alu_operand_q <= issue_opd;
                alu_opcode_q  <= (issue_kind == KindExec) ? issue_opc : '0;
                alu_write_q   <= (issue_kind == KindLoad);
                alu_writeu_q  <= (issue_kind == KindLoadU);
                alu_read_q    <= (issue_kind == KindRead);
            end
        end
    end

    assign bus_io.in_ready    = in_ready_q;
    assign bus_io.alu_opcode  = alu_opcode_q;
    assign bus_io.alu_operand = alu_operand_q;
    assign bus_io.alu_write   = alu_write_q;
    assign bus_io.alu_writeu  = alu_writeu_q;
    assign bus_io.alu_read    = alu_read_q;
    assign bus_io.res_valid   = res_valid_q;
    assign bus_io.res_data    = res_data_q;
    assign bus_io.res_flag    = res_flag_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed and randomized bench for alu_issue_ctrl.
module tb_alu_issue_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    alu_issue_ctrl_if #(.DATA_W(16), .OPC_W(5)) bus ();

    alu_issue_ctrl #(
        .DATA_W (16),
        .OPC_W  (5)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_strb(input string tag, input logic w, input logic wu, input logic r);
        chk({tag, "_write"},  {31'd0, bus.alu_write},  {31'd0, w});
        chk({tag, "_writeu"}, {31'd0, bus.alu_writeu}, {31'd0, wu});
        chk({tag, "_read"},   {31'd0, bus.alu_read},   {31'd0, r});
    endtask

    // Random-phase model state
    logic [15:0] p_word, p_acc, e_opd, exp_opd, exp_data, f_word;
    logic        p_valid, p_ready, p_rr, p_flag, acc, have_first, e_iss, exp_flag, exp_rv;
    logic [1:0]  e_kind;
    logic [4:0]  e_opc;
    int          rd_stage;
    int          nstrb;

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_word    = '0;
        bus.alu_accout = '0;
        bus.alu_flag   = 1'b0;
        bus.res_ready  = 1'b0;

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd0);
        chk("rst_opcode",    {27'd0, bus.alu_opcode}, 32'd0);
        chk("rst_operand",   {16'd0, bus.alu_operand}, 32'd0);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_res_data",  {16'd0, bus.res_data}, 32'd0);
        chk("rst_res_flag",  {31'd0, bus.res_flag}, 32'd0);
        chk_strb("rst", 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("rst_hold_ready", {31'd0, bus.in_ready}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", {31'd0, bus.in_ready}, 32'd1);

        // LOAD with extension word
        bus.in_valid = 1'b1;
        bus.in_word  = 16'h4100;
        step();
        chk_strb("ld_wait", 1'b0, 1'b0, 1'b0);
        chk("ld_wait_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_word = 16'hFFFE;
        step();
        chk_strb("ld_issue", 1'b1, 1'b0, 1'b0);
        chk("ld_operand", {16'd0, bus.alu_operand}, 32'h0000FFFE);
        chk("ld_opcode",  {27'd0, bus.alu_opcode}, 32'd0);
        chk("ld_ready",   {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;
        step();
        chk_strb("ld_after", 1'b0, 1'b0, 1'b0);
        chk("ld_after_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("ld_operand_hold", {16'd0, bus.alu_operand}, 32'h0000FFFE);

        // EXEC with immediate
        bus.in_valid = 1'b1;
        bus.in_word  = 16'h0405;
        step();
        chk("ex_opcode",  {27'd0, bus.alu_opcode}, 32'd2);
        chk("ex_operand", {16'd0, bus.alu_operand}, 32'h5);
        chk_strb("ex_issue", 1'b0, 1'b0, 1'b0);
        chk("ex_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;
        step();
        chk("ex_opcode_clr", {27'd0, bus.alu_opcode}, 32'd0);
        chk("ex_ready_back", {31'd0, bus.in_ready}, 32'd1);

        // READ with stalled consumer; a pending word must not be taken
        bus.alu_accout = 16'h1234;
        bus.alu_flag   = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_word    = 16'hC000;
        step();
        chk_strb("rd_issue", 1'b0, 1'b0, 1'b1);
        chk("rd_opcode", {27'd0, bus.alu_opcode}, 32'd0);
        bus.in_valid = 1'b0;
        step();
        chk_strb("rd_capture", 1'b0, 1'b0, 1'b0);
        chk("rd_capture_rv", {31'd0, bus.res_valid}, 32'd0);
        step();
        bus.alu_accout = 16'h0000;
        bus.alu_flag   = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_word    = 16'h0405;
        for (int i = 0; i < 5; i++) begin
            chk("rd_hold_rv",    {31'd0, bus.res_valid}, 32'd1);
            chk("rd_hold_data",  {16'd0, bus.res_data}, 32'h1234);
            chk("rd_hold_flag",  {31'd0, bus.res_flag}, 32'd1);
            chk("rd_hold_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("rd_hold_opc",   {27'd0, bus.alu_opcode}, 32'd0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        chk("rd_done_rv",    {31'd0, bus.res_valid}, 32'd0);
        chk("rd_done_ready", {31'd0, bus.in_ready}, 32'd1);

        // LOADU with gap before extension word
        bus.in_valid = 1'b1;
        bus.in_word  = 16'h8100;
        step();
        bus.in_valid = 1'b0;
        bus.in_word  = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("ldu_gap_ready", {31'd0, bus.in_ready}, 32'd1);
            chk_strb("ldu_gap", 1'b0, 1'b0, 1'b0);
        end
        bus.in_valid = 1'b1;
        bus.in_word  = 16'hFF00;
        step();
        chk_strb("ldu_issue", 1'b0, 1'b1, 1'b0);
        chk("ldu_operand", {16'd0, bus.alu_operand}, 32'h0000FF00);
        bus.in_valid = 1'b0;
        step();
        chk_strb("ldu_after", 1'b0, 1'b0, 1'b0);

        // Reset abort in WAIT_EXT
        bus.in_valid = 1'b1;
        bus.in_word  = 16'h4100;
        step();
        rst_n = 1'b0;
        #1;
        chk("ab1_ready",   {31'd0, bus.in_ready}, 32'd0);
        chk("ab1_operand", {16'd0, bus.alu_operand}, 32'd0);
        chk("ab1_rv",      {31'd0, bus.res_valid}, 32'd0);
        bus.in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("ab1_ready_back", {31'd0, bus.in_ready}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            chk_strb("ab1_quiet", 1'b0, 1'b0, 1'b0);
            step();
        end

        // Reset abort in CAPTURE
        bus.alu_accout = 16'hBEEF;
        bus.alu_flag   = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_word    = 16'hC000;
        step();
        chk_strb("ab2_issue", 1'b0, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("ab2_rv",       {31'd0, bus.res_valid}, 32'd0);
        chk("ab2_res_data", {16'd0, bus.res_data}, 32'd0);
        chk("ab2_ready",    {31'd0, bus.in_ready}, 32'd0);
        chk_strb("ab2_rst", 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ab2_quiet_rv", {31'd0, bus.res_valid}, 32'd0);
            chk_strb("ab2_quiet", 1'b0, 1'b0, 1'b0);
        end
        bus.in_valid = 1'b1;
        bus.in_word  = 16'h4007;
        step();
        chk_strb("ab2_load", 1'b1, 1'b0, 1'b0);
        chk("ab2_load_opd", {16'd0, bus.alu_operand}, 32'h7);
        bus.in_valid = 1'b0;
        step();

        // Randomized stream against a latency-rule model
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        have_first = 1'b0;
        rd_stage   = 0;
        exp_opd    = '0;
        exp_rv     = 1'b0;
        exp_data   = '0;
        exp_flag   = 1'b0;
        f_word     = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus.in_valid   = ($urandom_range(0, 3) != 0);
            bus.in_word    = 16'($urandom);
            bus.res_ready  = ($urandom_range(0, 2) == 0);
            bus.alu_accout = 16'($urandom);
            bus.alu_flag   = 1'($urandom);
            p_valid = bus.in_valid;
            p_word  = bus.in_word;
            p_ready = bus.in_ready;
            p_rr    = bus.res_ready;
            p_acc   = bus.alu_accout;
            p_flag  = bus.alu_flag;
            step();

            // What the last edge accepted, and what it issues now
            acc    = p_valid && p_ready;
            e_iss  = 1'b0;
            e_kind = 2'd0;
            e_opc  = 5'd0;
            e_opd  = '0;
            if (acc) begin
                if (!have_first) begin
                    if (p_word[8]) begin
                        have_first = 1'b1;
                        f_word     = p_word;
                    end else begin
                        e_iss  = 1'b1;
                        e_kind = p_word[15:14];
                        e_opc  = p_word[13:9];
                        e_opd  = {8'h00, p_word[7:0]};
                    end
                end else begin
                    have_first = 1'b0;
                    e_iss  = 1'b1;
                    e_kind = f_word[15:14];
                    e_opc  = f_word[13:9];
                    e_opd  = p_word;
                end
            end
            if (e_iss) exp_opd = e_opd;

            // READ result: issue, then capture cycle, then held until taken
            if (rd_stage == 3 && p_rr) begin
                rd_stage = 0;
                exp_rv   = 1'b0;
            end else if (rd_stage == 2) begin
                rd_stage = 3;
                exp_rv   = 1'b1;
                exp_data = p_acc;
                exp_flag = p_flag;
            end else if (rd_stage == 1) begin
                rd_stage = 2;
            end
            if (e_iss && e_kind == 2'b11) rd_stage = 1;

            nstrb = int'(bus.alu_write) + int'(bus.alu_writeu) + int'(bus.alu_read);
            chk("rnd_one_strobe", {31'd0, nstrb <= 1}, 32'd1);
            chk("rnd_ready", {31'd0, bus.in_ready}, {31'd0, !e_iss && rd_stage == 0});
            chk_strb("rnd", e_iss && e_kind == 2'b01, e_iss && e_kind == 2'b10,
                     e_iss && e_kind == 2'b11);
            chk("rnd_opcode", {27'd0, bus.alu_opcode},
                {27'd0, (e_iss && e_kind == 2'b00) ? e_opc : 5'd0});
            chk("rnd_operand", {16'd0, bus.alu_operand}, {16'd0, exp_opd});
            chk("rnd_res_valid", {31'd0, bus.res_valid}, {31'd0, exp_rv});
            if (exp_rv) begin
                chk("rnd_res_data", {16'd0, bus.res_data}, {16'd0, exp_data});
                chk("rnd_res_flag", {31'd0, bus.res_flag}, {31'd0, exp_flag});
            end
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
